// File: rtl/r4_srt_frac_div_seq.sv
// r4_srt_frac_div_seq: sequential radix-4 SRT significand divider, digits {-2..+2}.
// Optional macro R4_DIV_POW2_BYPASS_EN: a 2^(WIDTH-1) divisor skips the iterations.
module r4_srt_frac_div_seq #(
    parameter  int WIDTH = 24,
    localparam int ITER  = (WIDTH + 2) / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             finish_valid_o,
    input  logic             finish_ready_i,
    output logic [WIDTH:0]   quo_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             rem_zero_o
);
    localparam int RW = WIDTH + 4;
    localparam int QW = WIDTH + 1;
    localparam int CW = $clog2(ITER);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_ITER, S_POST, S_DONE
    } state_t;

    state_t           r_state;
    logic             r_sready;
    logic             r_fvalid;
    logic [QW-1:0]    r_quo;
    logic [WIDTH-1:0] r_rem;
    logic             r_zero;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_d;
    logic [2:0]       r_didx;
    logic [RW-1:0]    r_dp1;
    logic [RW-1:0]    r_dp2;
    logic [RW-1:0]    r_dn1;
    logic [RW-1:0]    r_dn2;
    logic [RW-1:0]    r_ws;
    logic [RW-1:0]    r_wc;
    logic [QW-1:0]    r_q;
    logic [QW-1:0]    r_qm;
    logic [CW-1:0]    r_cnt;
`ifdef R4_DIV_POW2_BYPASS_EN
    logic             r_byp;
    logic             w_p2;
`endif

    logic [RW-1:0]     w_d4;
    logic [RW-1:0]     w_d8;
    logic signed [6:0] w_est;
    logic signed [6:0] w_m2;
    logic signed [6:0] w_m1;
    logic signed [6:0] w_m0;
    logic signed [6:0] w_mn1;
    logic              w_ge2;
    logic              w_ge1;
    logic              w_ge0;
    logic              w_gen1;
    logic [4:0]        w_dig;
    logic [RW-1:0]     w_add;
    logic [QW-1:0]     w_qn;
    logic [QW-1:0]     w_qmn;
    logic [RW-1:0]     w_s4;
    logic [RW-1:0]     w_c4;
    logic [RW-1:0]     w_nsum;
    logic [RW-2:0]     w_maj;
    logic [RW-1:0]     w_fin;
    logic              w_neg;
    logic [WIDTH-1:0]  w_fix;
    logic [WIDTH-1:0]  w_rem;
    logic [QW-1:0]     w_quo;
    logic [RW-1:0]     w_abs;
    logic              w_bound_ok;

    assign w_d4 = {2'b00, r_d, 2'b00};
    assign w_d8 = {1'b0, r_d, 3'b000};
`ifdef R4_DIV_POW2_BYPASS_EN
    assign w_p2 = (r_d == {1'b1, {(WIDTH-1){1'b0}}});
`endif

    // Remainder LSB weighs 2^-(WIDTH+2); these bits are 4w with 4 fraction bits.
    assign w_est = r_ws[WIDTH+2:WIDTH-4] + r_wc[WIDTH+2:WIDTH-4];

    always_comb begin
        w_m2  = 7'sd24;
        w_m1  = 7'sd8;
        w_m0  = -7'sd8;
        w_mn1 = -7'sd24;
        unique case (r_didx)
            3'd0: begin w_m2 = 7'sd12; w_m1 = 7'sd4; w_m0 = -7'sd4; w_mn1 = -7'sd13; end
            3'd1: begin w_m2 = 7'sd14; w_m1 = 7'sd4; w_m0 = -7'sd6; w_mn1 = -7'sd15; end
            3'd2: begin w_m2 = 7'sd15; w_m1 = 7'sd4; w_m0 = -7'sd6; w_mn1 = -7'sd16; end
            3'd3: begin w_m2 = 7'sd16; w_m1 = 7'sd4; w_m0 = -7'sd6; w_mn1 = -7'sd18; end
            3'd4: begin w_m2 = 7'sd18; w_m1 = 7'sd6; w_m0 = -7'sd8; w_mn1 = -7'sd20; end
            3'd5: begin w_m2 = 7'sd20; w_m1 = 7'sd6; w_m0 = -7'sd8; w_mn1 = -7'sd20; end
            3'd6: begin w_m2 = 7'sd20; w_m1 = 7'sd8; w_m0 = -7'sd8; w_mn1 = -7'sd22; end
            3'd7: begin w_m2 = 7'sd24; w_m1 = 7'sd8; w_m0 = -7'sd8; w_mn1 = -7'sd24; end
            default: ;
        endcase
    end

    assign w_ge2  = (w_est >= w_m2);
    assign w_ge1  = (w_est >= w_m1);
    assign w_ge0  = (w_est >= w_m0);
    assign w_gen1 = (w_est >= w_mn1);
    assign w_dig  = {~w_gen1, w_gen1 & ~w_ge0, w_ge0 & ~w_ge1,
                     w_ge1 & ~w_ge2, w_ge2};

    always_comb begin
        w_add = '0;
        w_qn  = {r_q[QW-3:0], 2'd0};
        w_qmn = {r_qm[QW-3:0], 2'd3};
        unique case (1'b1)
            w_dig[0]: begin
                w_add = r_dn2;
                w_qn  = {r_q[QW-3:0], 2'd2};
                w_qmn = {r_q[QW-3:0], 2'd1};
            end
            w_dig[1]: begin
                w_add = r_dn1;
                w_qn  = {r_q[QW-3:0], 2'd1};
                w_qmn = {r_q[QW-3:0], 2'd0};
            end
            w_dig[2]: ;
            w_dig[3]: begin
                w_add = r_dp1;
                w_qn  = {r_qm[QW-3:0], 2'd3};
                w_qmn = {r_qm[QW-3:0], 2'd2};
            end
            w_dig[4]: begin
                w_add = r_dp2;
                w_qn  = {r_qm[QW-3:0], 2'd2};
                w_qmn = {r_qm[QW-3:0], 2'd1};
            end
            default: ;
        endcase
    end

    assign w_s4   = {r_ws[RW-3:0], 2'b00};
    assign w_c4   = {r_wc[RW-3:0], 2'b00};
    assign w_nsum = w_s4 ^ w_c4 ^ w_add;
    assign w_maj  = (w_s4[RW-2:0] & w_c4[RW-2:0])
                  | (w_s4[RW-2:0] & w_add[RW-2:0])
                  | (w_c4[RW-2:0] & w_add[RW-2:0]);

    // After the first step the two low remainder bits are always zero.
    assign w_fin = r_ws + r_wc;
    assign w_neg = w_fin[RW-1];
    assign w_fix = w_fin[WIDTH+1:2] + r_d;
    assign w_rem = w_neg ? w_fix : w_fin[WIDTH+1:2];
    assign w_quo = w_neg ? r_qm : r_q;

    assign w_abs      = w_neg ? (~w_fin + 1'b1) : w_fin;
    assign w_bound_ok = ({2'b00, w_abs} + {1'b0, w_abs, 1'b0})
                        <= {1'b0, w_d4, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sready <= 1'b1;
            r_fvalid <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_zero   <= 1'b0;
        end else if (flush_i) begin
            r_state  <= S_IDLE;
            r_sready <= 1'b1;
            r_fvalid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_valid_i && r_sready) begin
                        r_x      <= dividend_i;
                        r_d      <= divisor_i;
                        r_sready <= 1'b0;
                        r_state  <= S_PRE;
                    end
                end
                S_PRE: begin
                    r_ws   <= {4'b0000, r_x};
                    r_wc   <= '0;
                    r_didx <= r_d[WIDTH-2:WIDTH-4];
                    r_dp1  <= w_d4;
                    r_dp2  <= w_d8;
                    r_dn1  <= -w_d4;
                    r_dn2  <= -w_d8;
                    r_q    <= '0;
                    r_qm   <= '1;
                    r_cnt  <= CW'(ITER - 1);
`ifdef R4_DIV_POW2_BYPASS_EN
                    r_byp   <= w_p2;
                    r_state <= w_p2 ? S_POST : S_ITER;
`else
                    r_state <= S_ITER;
`endif
                end
                S_ITER: begin
                    r_ws  <= w_nsum;
                    r_wc  <= {w_maj, 1'b0};
                    r_q   <= w_qn;
                    r_qm  <= w_qmn;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= S_POST;
                end
                S_POST: begin
                    r_quo    <= w_quo;
                    r_rem    <= w_rem;
                    r_zero   <= (w_rem == '0);
`ifdef R4_DIV_POW2_BYPASS_EN
                    if (r_byp) begin
                        r_quo  <= {r_x, 1'b0};
                        r_rem  <= '0;
                        r_zero <= 1'b1;
                    end
`endif
                    r_fvalid <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (finish_ready_i) begin
                        r_fvalid <= 1'b0;
                        r_sready <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    a_wbound: assert property (@(posedge clk) disable iff (rst)
        (r_state == S_ITER || r_state == S_POST) |-> w_bound_ok);

    assign start_ready_o  = r_sready;
    assign finish_valid_o = r_fvalid;
    assign quo_o          = r_quo;
    assign rem_o          = r_rem;
    assign rem_zero_o     = r_zero;
endmodule

// File: tb/tb_r4_srt_frac_div_seq.sv
// tb_r4_srt_frac_div_seq: directed WIDTH=8 checks of the radix-4 SRT divider,
// covering handshake, backpressure, flush/reset and a short operand sweep.
module tb_r4_srt_frac_div_seq;
    localparam int W = 8;
    localparam int LAT = 7;
`ifdef R4_DIV_POW2_BYPASS_EN
    localparam int LAT_P2 = 2;
`else
    localparam int LAT_P2 = 7;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready_o;
    logic         flush = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         finish_valid_o;
    logic         finish_ready = 1'b0;
    logic [W:0]   quo_o;
    logic [W-1:0] rem_o;
    logic         rem_zero_o;

    int n_tot = 0;
    int n_bad = 0;

    r4_srt_frac_div_seq #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_valid_i (start_valid),
        .start_ready_o (start_ready_o),
        .flush_i       (flush),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .finish_valid_o(finish_valid_o),
        .finish_ready_i(finish_ready),
        .quo_o         (quo_o),
        .rem_o         (rem_o),
        .rem_zero_o    (rem_zero_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] d,
                          output int lat);
        int g;
        g = 0;
        while (!start_ready_o && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("rdy_wait", start_ready_o, 1);
        dividend    = x;
        divisor     = d;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        lat = 0;
        while (!finish_valid_o && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("fin_seen", finish_valid_o, 1);
    endtask

    task automatic accept();
        finish_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        finish_ready = 1'b0;
        chk("acc_valid", finish_valid_o, 0);
        chk("acc_ready", start_ready_o, 1);
    endtask

    task automatic op_chk(input string tag, input logic [W-1:0] x,
                          input logic [W-1:0] d, input int elat,
                          input logic [W:0] eq, input logic [W-1:0] er,
                          input logic ez);
        int lat;
        run_op(x, d, lat);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_quo"}, quo_o, eq);
        chk({tag, "_rem"}, rem_o, er);
        chk({tag, "_zero"}, rem_zero_o, ez);
        accept();
    endtask

    initial begin
        int lat;
        int seen;
        logic [W-1:0] x;
        logic [W-1:0] d;
        int unsigned num;
        int unsigned eq;
        int unsigned er;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", start_ready_o, 1);
        chk("rst_valid", finish_valid_o, 0);
        chk("rst_quo", quo_o, 0);
        chk("rst_rem", rem_o, 0);
        chk("rst_zero", rem_zero_o, 0);

        op_chk("v80c0", 8'h80, 8'hC0, LAT, 9'h0AA, 8'h80, 1'b0);
        op_chk("vff80", 8'hFF, 8'h80, LAT_P2, 9'h1FE, 8'h00, 1'b1);
        op_chk("vc0c0", 8'hC0, 8'hC0, LAT, 9'h100, 8'h00, 1'b1);
        op_chk("v80ff", 8'h80, 8'hFF, LAT, 9'h080, 8'h80, 1'b0);

        // Backpressure: result held for 10 cycles, then a start on release.
        run_op(8'hA0, 8'hE0, lat);
        chk("bp_lat", lat, LAT);
        for (int i = 0; i < 10; i++) begin
            chk("bp_quo", quo_o, 9'h0B6);
            chk("bp_rem", rem_o, 8'hC0);
            chk("bp_valid", finish_valid_o, 1);
            chk("bp_ready", start_ready_o, 0);
            @(negedge clk);
        end
        finish_ready = 1'b1;
        start_valid  = 1'b1;
        dividend     = 8'hFF;
        divisor      = 8'hC0;
        @(posedge clk);
        @(negedge clk);
        finish_ready = 1'b0;
        start_valid  = 1'b0;
        chk("rel_valid", finish_valid_o, 0);
        chk("rel_ready", start_ready_o, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (finish_valid_o) seen++;
        end
        chk("ign_start", seen, 0);
        chk("ign_ready", start_ready_o, 1);

        // Flush during the third iteration cycle.
        dividend    = 8'h80;
        divisor     = 8'hC0;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("fl_ready", start_ready_o, 1);
        chk("fl_valid", finish_valid_o, 0);
        chk("fl_quo", quo_o, 9'h0B6);

        // Reset pulse while in PRE.
        dividend    = 8'hC0;
        divisor     = 8'hC0;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rp_ready", start_ready_o, 1);
        chk("rp_valid", finish_valid_o, 0);
        chk("rp_quo", quo_o, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (finish_valid_o) seen++;
        end
        chk("rp_quiet", seen, 0);
        op_chk("post", 8'h80, 8'hC0, LAT, 9'h0AA, 8'h80, 1'b0);

        // Short sweep against integer division.
        for (int k = 0; k < 40; k++) begin
            x   = 8'h80 | 8'($urandom_range(0, 127));
            d   = 8'h80 | 8'($urandom_range(0, 127));
            if (k == 0) d = 8'h80;
            if (k == 1) d = 8'hFF;
            num = {16'h0, x, 8'h00};
            eq  = num / {24'h0, d};
            er  = num - eq * {24'h0, d};
            op_chk("rnd", x, d, (d == 8'h80) ? LAT_P2 : LAT,
                   9'(eq), 8'(er), (er == 0));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", n_tot, n_bad);
        $fatal(1, "watchdog expired");
    end
endmodule
